// File: rtl/mppt_pkg.sv
// Shared constants for the MPPT datapath: op codes, compare codes,
// arbiter state encoding and Q16.16 helpers.
package mppt_pkg;

  // fixed_point_math operation codes
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;

  // fixed_point_math compare_result codes
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Arbiter FSM encoding
  localparam int         ST_W     = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Q16.16 constants
  localparam int          Q_FRAC_BITS = 16;
  localparam logic [31:0] Q16_ZERO    = 32'h0000_0000;
  localparam logic [31:0] Q16_ONE     = 32'h0001_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr,
// wrapping modulo NUM_REQ. Produces a one-hot winner and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] k;
  logic             found;

  // Scan from ptr upward; the first hit wins and later hits are masked.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    k       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      k = sum[PTR_W-1:0];
      if (!found && req[k]) begin
        found      = 1'b1;
        gnt[k]     = 1'b1;
        gnt_idx    = k;
      end
    end
  end

endmodule

// File: rtl/fixed_point_math_arbiter.sv
// Shares one Q16.16 fixed_point_math unit between NUM_REQ requesters.
// Round robin, one outstanding operation, watchdog on math_done.
module fixed_point_math_arbiter
  import mppt_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b,
  input  logic [NUM_REQ*3-1:0]          req_operation,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            rsp_done,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow,
  output logic [1:0]                    rsp_compare,
  output logic                          rsp_timeout,
  output logic [DATA_WIDTH-1:0]         math_op_a,
  output logic [DATA_WIDTH-1:0]         math_op_b,
  output logic [2:0]                    math_operation,
  output logic                          math_start,
  input  logic [DATA_WIDTH-1:0]         math_result,
  input  logic                          math_done,
  input  logic                          math_overflow,
  input  logic [1:0]                    math_compare,
  output logic                          busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [ST_W-1:0]       state_q,  state_d;
  logic [NUM_REQ-1:0]    grant_q,  grant_d;
  logic [PTR_W-1:0]      owner_q,  owner_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0] op_a_q,   op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q,   op_b_d;
  logic [2:0]            opn_q,    opn_d;
  logic [DATA_WIDTH-1:0] res_q,    res_d;
  logic                  ovf_q,    ovf_d;
  logic [1:0]            cmp_q,    cmp_d;
  logic                  tmo_q,    tmo_d;

  logic [NUM_REQ-1:0]    win_gnt;
  logic [PTR_W-1:0]      win_idx;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic [2:0]            sel_op;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (win_gnt),
    .gnt_idx (win_idx)
  );

  // One-hot OR-mux of the winning requester's operands and op code.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_gnt[k]) begin
        sel_a  = sel_a  | req_op_a[k*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = sel_b  | req_op_b[k*DATA_WIDTH +: DATA_WIDTH];
        sel_op = sel_op | req_operation[k*3 +: 3];
      end
    end
  end

  // Transaction FSM: grant/latch, issue, wait (with watchdog), respond.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    opn_d    = opn_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    cmp_d    = cmp_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ISSUE;
          grant_d = win_gnt;
          owner_d = win_idx;
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          opn_d   = sel_op;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (math_done) begin
          state_d = ST_RESP;
          res_d   = math_result;
          ovf_d   = math_overflow;
          cmp_d   = math_compare;
          tmo_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Watchdog: abort with a zeroed response once the budget is spent.
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d = ST_RESP;
            res_d   = '0;
            ovf_d   = 1'b0;
            cmp_d   = 2'b00;
            tmo_d   = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        rr_ptr_d = (owner_q == PTR_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; the math unit itself is not reset here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opn_q    <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      cmp_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opn_q    <= opn_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      cmp_q    <= cmp_d;
      tmo_q    <= tmo_d;
    end
  end

  assign grant          = grant_q;
  assign rsp_done       = (state_q == ST_RESP) ? grant_q : '0;
  assign rsp_result     = res_q;
  assign rsp_overflow   = ovf_q;
  assign rsp_compare    = cmp_q;
  assign rsp_timeout    = tmo_q;
  assign math_op_a      = op_a_q;
  assign math_op_b      = op_b_q;
  assign math_operation = opn_q;
  assign math_start     = (state_q == ST_ISSUE);
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fixed_point_math_arbiter.sv
// Directed bench for fixed_point_math_arbiter with a behavioural Q16.16 math model.
module tb_fixed_point_math_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_op_a, req_op_b;
  logic [NR*3-1:0]   req_operation;
  logic [NR-1:0]     grant, rsp_done;
  logic [DW-1:0]     rsp_result, math_op_a, math_op_b, math_result;
  logic              rsp_overflow, rsp_timeout, math_start, math_done, math_overflow, busy;
  logic [1:0]        rsp_compare, math_compare;
  logic [2:0]        math_operation;

  always #5 clk = ~clk;

  fixed_point_math_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op_a(req_op_a), .req_op_b(req_op_b),
    .req_operation(req_operation), .grant(grant), .rsp_done(rsp_done),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_compare(rsp_compare),
    .rsp_timeout(rsp_timeout), .math_op_a(math_op_a), .math_op_b(math_op_b),
    .math_operation(math_operation), .math_start(math_start), .math_result(math_result),
    .math_done(math_done), .math_overflow(math_overflow), .math_compare(math_compare),
    .busy(busy)
  );

  // ---------------- math unit model ----------------
  logic          model_en = 1'b1;
  int            lat = 1;
  int            pend = 0;
  logic          m_done = 1'b0, inj_done = 1'b0, m_ovf = 1'b0, ovf_force = 1'b0;
  logic [DW-1:0] m_res = '0, inj_res = '0;
  logic [1:0]    m_cmp = '0;

  function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic signed [63:0] sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: begin p = sa * sb; return p[47:16]; end
      3'd3: begin p = (sa <<< 16) / sb; return p[31:0]; end
      3'd4: return 32'h0;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [1:0] cmpf(input logic [31:0] a, input logic [31:0] b);
    if ($signed(a) == $signed(b)) return 2'b00;
    if ($signed(a) >  $signed(b)) return 2'b01;
    return 2'b10;
  endfunction

  always @(posedge clk) begin
    if (math_start && model_en) begin
      m_res <= calc(math_op_a, math_op_b, math_operation);
      m_cmp <= cmpf(math_op_a, math_op_b);
      m_ovf <= ovf_force;
      if (lat <= 1) begin m_done <= 1'b1; pend <= 0; end
      else          begin m_done <= 1'b0; pend <= lat - 1; end
    end else if (pend != 0) begin
      pend   <= pend - 1;
      m_done <= (pend == 1);
    end else begin
      m_done <= 1'b0;
    end
  end

  assign math_done     = m_done | inj_done;
  assign math_result   = inj_done ? inj_res : m_res;
  assign math_overflow = m_ovf;
  assign math_compare  = m_cmp;

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0, multi_grant = 0;

  always @(negedge clk) if ($countones(grant) > 1) multi_grant++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // One transaction from IDLE for a single requester mask; operands are
  // scrambled the cycle after grant to prove they were latched.
  task automatic run_txn(input string tag, input logic [NR-1:0] mask,
                         input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic ovf, input logic [31:0] eres, input logic [1:0] ecmp,
                         input logic etmo, input int lat_lo, input int lat_hi);
    int  cyc;
    bit  got;
    @(negedge clk);
    ovf_force = ovf;
    for (int k = 0; k < NR; k++) if (mask[k]) begin
      req_op_a[k*DW +: DW]    = a;
      req_op_b[k*DW +: DW]    = b;
      req_operation[k*3 +: 3] = op;
    end
    req = mask;
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        chk({tag, " start"}, 64'(math_start), 64'd1);
        chk({tag, " grant"}, 64'(grant), 64'(mask));
        req_op_a = ~req_op_a;
        req_op_b = ~req_op_b;
        req_operation = ~req_operation;
      end
      if (rsp_done != '0) got = 1;
    end
    chk({tag, " done seen"}, 64'(got), 64'd1);
    n_chk++;
    if (cyc < lat_lo || cyc > lat_hi) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d..%0d", tag, cyc, lat_lo, lat_hi);
    end
    chk({tag, " rsp_done"}, 64'(rsp_done), 64'(mask));
    chk({tag, " result"},   64'(rsp_result), 64'(eres));
    chk({tag, " ovf"},      64'(rsp_overflow), 64'(ovf));
    chk({tag, " cmp"},      64'(rsp_compare), 64'(ecmp));
    chk({tag, " timeout"},  64'(rsp_timeout), 64'(etmo));
    chk({tag, " op_a held"}, 64'(math_op_a), 64'(a));
    chk({tag, " op held"},   64'(math_operation), 64'(op));
    @(negedge clk); req = '0;
    @(posedge clk); #1;
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    logic [31:0]   a, b;
    logic [2:0]    op;
    logic          ovf;
    logic [31:0]   eres;
    logic [1:0]    ecmp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  cyc;
    logic [NR-1:0] exp_g;

    vecs[0] = '{2'b01, 32'h0001_8000, 32'h0002_4000, 3'd0, 1'b0, 32'h0003_C000, 2'b10};
    vecs[1] = '{2'b10, 32'h0006_0000, 32'h0002_0000, 3'd3, 1'b1, 32'h0003_0000, 2'b01};
    vecs[2] = '{2'b01, 32'h0001_0000, 32'h0003_0000, 3'd1, 1'b0, 32'hFFFE_0000, 2'b10};
    vecs[3] = '{2'b10, 32'h0002_0000, 32'h0001_8000, 3'd2, 1'b0, 32'h0003_0000, 2'b01};
    vecs[4] = '{2'b01, 32'h0001_0000, 32'h0002_0000, 3'd4, 1'b0, 32'h0000_0000, 2'b10};
    vecs[5] = '{2'b10, 32'hFFFF_0000, 32'hFFFF_0000, 3'd4, 1'b0, 32'h0000_0000, 2'b00};
    vecs[6] = '{2'b01, 32'h0F0F_0000, 32'h00FF_0000, 3'd6, 1'b0, 32'h0FF0_0000, 2'b01};

    rst = 1'b1; req = '0; req_op_a = '0; req_op_b = '0; req_operation = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset busy",   64'(busy), 64'd0);
    chk("reset grant",  64'(grant), 64'd0);
    chk("reset done",   64'(rsp_done), 64'd0);
    chk("reset start",  64'(math_start), 64'd0);
    chk("reset result", 64'(rsp_result), 64'd0);
    chk("reset op_a",   64'(math_op_a), 64'd0);

    // Table of single-requester transactions, L=1 -> rsp_done exactly 3 cycles after req.
    for (int i = 0; i < 7; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].ovf, vecs[i].eres, vecs[i].ecmp, 1'b0, 3, 3);
    ovf_force = 1'b0;

    // Contention: both held, rr_ptr=0 after reset -> 01,10,01,10.
    do_reset();
    @(negedge clk);
    req_op_a = {32'h0005_0000, 32'h0001_0000};
    req_op_b = {32'h0001_0000, 32'h0001_0000};
    req_operation = '0;
    multi_grant = 0;
    req = 2'b11;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      cyc = 0;
      while (rsp_done == '0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
      chk($sformatf("rr%0d done", n), 64'(rsp_done), 64'(exp_g));
      chk($sformatf("rr%0d grant", n), 64'(grant), 64'(exp_g));
      chk($sformatf("rr%0d result", n), 64'(rsp_result),
          (n % 2 == 0) ? 64'h0002_0000 : 64'h0006_0000);
      @(posedge clk); #1;
    end
    @(negedge clk); req = '0;
    repeat (2) @(posedge clk);
    chk("one-hot grant", 64'(multi_grant), 64'd0);

    // Watchdog: model silent -> zeroed response with timeout flag.
    model_en = 1'b0;
    run_txn("tmo", 2'b01, 32'h0001_0000, 32'h0001_0000, 3'd0, 1'b0, 32'h0, 2'b00, 1'b1, 64, 68);
    model_en = 1'b1;
    // Stale done in IDLE must be ignored.
    @(negedge clk); inj_res = 32'h1234_5678; inj_done = 1'b1;
    @(negedge clk); inj_done = 1'b0;
    cyc = 0;
    repeat (4) begin @(posedge clk); #1; if (rsp_done != '0 || busy) cyc++; end
    chk("stale done ignored", 64'(cyc), 64'd0);
    run_txn("post-tmo", 2'b01, 32'h0000_8000, 32'h0000_8000, 3'd0, 1'b0, 32'h0001_0000, 2'b00, 1'b0, 3, 3);

    // Reset mid-WAIT: abort, no rsp_done, rr_ptr back to 0 (owner 0 left it at 1).
    lat = 10;
    @(negedge clk);
    req_op_a[DW +: DW] = 32'h0001_0000; req_op_b[DW +: DW] = 32'h0001_0000; req_operation = '0;
    req = 2'b10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midwait busy", 64'(busy), 64'd1);
    @(negedge clk); rst = 1'b1; req = '0;
    @(posedge clk); #1;
    chk("rst busy",  64'(busy), 64'd0);
    chk("rst grant", 64'(grant), 64'd0);
    chk("rst done",  64'(rsp_done), 64'd0);
    chk("rst start", 64'(math_start), 64'd0);
    @(negedge clk); rst = 1'b0;
    cyc = 0;
    repeat (15) begin @(posedge clk); #1; if (rsp_done != '0 || busy) cyc++; end
    chk("late done ignored", 64'(cyc), 64'd0);
    lat = 1;
    @(negedge clk);
    req_op_a = {32'h0005_0000, 32'h0001_0000};
    req = 2'b11;
    cyc = 0;
    while (rsp_done == '0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("rr_ptr reset", 64'(rsp_done), 64'b01);
    @(negedge clk); req = '0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_point_math_arbiter.md
Name: fixed_point_math_arbiter

Overview:
- Shares one fixed_point_math instance (Q16.16) between NUM_REQ requesters, for example mppt_ic_core and a PI voltage-loop block, so only one divider/multiplier is built.
- Round-robin arbitration with a single outstanding operation.
- Latches operands on grant, drives the math unit's start/operand/operation pins, and routes result/overflow/compare back to the granted requester with a one-cycle done pulse.
- A watchdog reports a timeout if the math unit never returns done.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_WIDTH, 32, operand/result width (Q16.16).
- TIMEOUT_CYCLES, 64, maximum cycles to wait for math_done before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_op_a  in  NUM_REQ*DATA_WIDTH  flattened operand A; slice k = [k*DATA_WIDTH +: DATA_WIDTH].
- req_op_b  in  NUM_REQ*DATA_WIDTH  flattened operand B.
- req_operation  in  NUM_REQ*3  flattened op code.
- grant  out  NUM_REQ  one-hot owner of the current transaction.
- rsp_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- rsp_result  out  DATA_WIDTH  result, shared bus, valid while rsp_done is high.
- rsp_overflow  out  1  math overflow flag, valid with rsp_done.
- rsp_compare  out  2  compare result, valid with rsp_done.
- rsp_timeout  out  1  transaction aborted by watchdog, valid with rsp_done.
- math_op_a  out  DATA_WIDTH  to fixed_point_math operand_a.
- math_op_b  out  DATA_WIDTH  to operand_b.
- math_operation  out  3  to operation.
- math_start  out  1  to start.
- math_result  in  DATA_WIDTH  from result.
- math_done  in  1  from done.
- math_overflow  in  1  from overflow.
- math_compare  in  2  from compare_result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, all outputs 0, rr_ptr=0, timeout counter=0.
- State machine:
  - IDLE -> ISSUE when any req bit is high.
  - ISSUE -> WAIT, always, after one cycle.
  - WAIT -> RESP on math_done, or when the counter reaches TIMEOUT_CYCLES.
  - RESP -> IDLE, always, after one cycle.
- Arbitration (in IDLE):
  - Winner is the first set req bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - On the IDLE->ISSUE edge, grant becomes one-hot for the winner, and the winner's operands and op code are latched into math_op_a, math_op_b and math_operation.
- ISSUE: math_start=1 for exactly this one cycle; the timeout counter clears.
- WAIT:
  - math_start=0; the counter increments each cycle.
  - math_done is honoured from the first WAIT cycle onward. On math_done, capture result/overflow/compare and set rsp_timeout=0.
  - If the counter reaches TIMEOUT_CYCLES first, set rsp_result=0, rsp_overflow=0, rsp_compare=0, rsp_timeout=1.
- RESP:
  - rsp_done[owner]=1 for one cycle.
  - rr_ptr = owner+1, wrapping to 0 past NUM_REQ-1.
  - grant clears on the RESP->IDLE edge.
- Latency: req seen in IDLE at cycle 0 -> math_start at cycle 1 -> math_done at cycle 1+L -> rsp_done at cycle 2+L. Next grant is no earlier than cycle 3+L.
- Requester protocol:
  - Hold req high until rsp_done is seen. Dropping req after grant does not abort; rsp_done is still issued.
  - Operands are latched at grant, so the requester may change them after grant.
- Held req: a req still high in the IDLE cycle after RESP is a new request.
- Simultaneous requests: exactly one grant; a losing requester is served within NUM_REQ transactions (round robin, no starvation).
- math_done outside WAIT (stale pulse after reset or after a timeout): ignored.
- Reset mid-transaction: return to IDLE next edge, with no rsp_done and math_start=0. The math unit is not reset by this block, and any late done is ignored.
- Operation codes are passed through unchanged; codes 5-7 are not checked and are handled by the math unit.

Decomposition:
- Shared package mppt_pkg:
  - Op codes: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_CMP=4.
  - Compare codes: CMP_EQ=00, CMP_GT=01, CMP_LT=10.
  - Arbiter state encoding.
  - Q16.16 constants.
- Sub-module rr_arbiter (combinational priority pick from req and rr_ptr, giving a one-hot winner); the FSM stays in the top module.

Test Plan:
- Single ADD: req[0] with A=0x0001_8000, B=0x0002_4000, op=0; model returns done after L=1.
  -> math_start at cycle 1; rsp_done[0] at cycle 3; rsp_result=0x0003_C000; rsp_timeout=0.
- Contention: req=2'b11 held continuously with rr_ptr=0.
  -> grant sequence 01,10,01,10; each rsp_done goes to the matching index; never two grants at once.
- Timeout: model never raises done, TIMEOUT_CYCLES=64.
  -> rsp_done[owner] with rsp_timeout=1 and rsp_result=0; a math_done injected afterwards in IDLE is ignored; the next request is served normally.
- DIV pass-through: req[1] A=0x0006_0000, B=0x0002_0000, op=3; model returns 0x0003_0000 with overflow=1.
  -> rsp_result=0x0003_0000, rsp_overflow=1, rsp_done[1] only.
- Reset mid-WAIT: assert rst for one cycle during WAIT.
  -> busy=0 and grant=0 next cycle; no rsp_done; rr_ptr=0.
- Operand latching: change req_op_a on the cycle after grant.
  -> math_op_a keeps the value from the grant cycle for the whole transaction.
